// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, result width, default result latency
// and the state type of the result collector's output stage.
package alu_pkg;

   localparam int ALU_RES_W = 16;
   localparam int ALU_LAT   = 2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } out_state_e;

endpackage

// File: rtl/alu_result_collector_sync_fifo.sv
// Circular-buffer FIFO with registered storage and an explicit occupancy counter;
// the head entry is read straight from the storage register at rd_ptr.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == CW'(0));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_result_collector.sv
// Realigns the ALU issue marker to its result latency, buffers valid results in a
// FIFO for a valid/ready consumer, and keeps a saturating sum and sticky drop flag.
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = alu_pkg::ALU_LAT,
   parameter int SUM_W   = 20
) (
   input  logic                      clk_p_i,
   input  logic                      reset_n_i,
   input  logic                      issue_valid_i,
   input  logic [ALU_RES_W-1:0]      data_i,
   input  logic                      clear_i,
   input  logic                      out_ready_i,
   output logic                      out_valid_o,
   output logic [ALU_RES_W-1:0]      out_data_o,
   output logic [SUM_W-1:0]          sum_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      full_o,
   output logic                      drop_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ALU_LAT-1:0] pipe_q, pipe_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic               drop_q, drop_d;
   out_state_e         state_q, state_d;

   logic               cap_s;
   logic               push_s;
   logic               pop_s;
   logic               drop_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [CW-1:0]      fifo_count_s;

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]     acc,
                                                input logic [ALU_RES_W-1:0] val);
      logic [SUM_W:0] wide;
      wide = {1'b0, acc} + {{(SUM_W + 1 - ALU_RES_W){1'b0}}, val};
      return wide[SUM_W] ? {SUM_W{1'b1}} : wide[SUM_W-1:0];
   endfunction

   assign cap_s  = pipe_q[ALU_LAT-1];
   assign pop_s  = out_valid_o & out_ready_i & ~fifo_empty_s;
   assign push_s = cap_s & (~fifo_full_s | pop_s);
   assign drop_s = cap_s & fifo_full_s & ~pop_s;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ALU_RES_W)
   ) u_fifo (
      .clk_i   (clk_p_i),
      .rst_n_i (reset_n_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (data_i),
      .rdata_o (out_data_o),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   assign count_o     = fifo_count_s;
   assign full_o      = fifo_full_s;
   assign out_valid_o = (state_q == ST_HOLD);
   assign sum_o       = sum_q;
   assign drop_o      = drop_q;

   // Alignment pipe: stage 0 samples the issue marker, last stage is the capture strobe
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = issue_valid_i;
      for (int i = 1; i < ALU_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Running sum and drop flag; a same-cycle drop outranks clear
   always_comb begin
      sum_d  = sum_q;
      drop_d = drop_q;
      if (clear_i) begin
         sum_d = push_s ? {{(SUM_W - ALU_RES_W){1'b0}}, data_i} : {SUM_W{1'b0}};
      end else if (push_s) begin
         sum_d = sat_add(sum_q, data_i);
      end else begin
         sum_d = sum_q;
      end
      if (drop_s) begin
         drop_d = 1'b1;
      end else if (clear_i) begin
         drop_d = 1'b0;
      end else begin
         drop_d = drop_q;
      end
   end

   // Output FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (push_s) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_HOLD: begin
            if (pop_s && !push_s && (fifo_count_s == CW'(1))) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State registers
   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pipe_q  <= '0;
         sum_q   <= '0;
         drop_q  <= 1'b0;
         state_q <= ST_EMPTY;
      end else begin
         pipe_q  <= pipe_d;
         sum_q   <= sum_d;
         drop_q  <= drop_d;
         state_q <= state_d;
      end
   end

endmodule
